regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback requesters (ALU, load unit, CSR unit) using round-robin arbitration.
- Drives the register file's one-hot write-enable vector, write data and write strobe through one registered output stage.
- Holds a per-register busy scoreboard so that issue logic can detect read-after-write hazards on rs1/rs2.
- Sits between the execute/memory units and the register file.

Parameters:
- WIDTH, 32, data width of one register.
- LENGTH, 32, number of registers; ADDR_W = $clog2(LENGTH).
- NREQ, 3, number of writeback requesters (>= 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  [0:NREQ-1]  requester i has a write pending.
- req_ready  out  [0:NREQ-1]  requester i is accepted this cycle (one-hot or zero).
- req_addr  in  NREQ*ADDR_W  destination register; requester i uses slice i.
- req_data  in  NREQ*WIDTH  write data; requester i uses slice i.
- alloc_valid  in  1  issue stage marks a destination as in-flight.
- alloc_addr  in  ADDR_W  register being allocated.
- flush  in  1  pipeline flush; clears the scoreboard.
- rs1_addr, rs2_addr  in  ADDR_W each  hazard query addresses.
- rs1_busy, rs2_busy  out  1 each  queried register has a write in flight.
- reg_write_en  out  [0:LENGTH-1]  one-hot register write select; bit i selects register i.
- write_data  out  [0:WIDTH-1]  data to the register file.
- write_en  out  1  write strobe for the register file.
- busy_vec  out  [0:LENGTH-1]  scoreboard state, for debug and verification.

Behaviour:
- Reset (asynchronous, rst=1):
  - rr_ptr=0 and all busy bits=0.
  - Output stage invalid: write_en=0, reg_write_en=0, write_data=0.
  - req_ready=0 while rst is asserted.
- Arbitration (combinational):
  - The grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... and wrapping modulo NREQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - If no requester is valid, req_ready=0 and there is no grant.
  - A requester holds valid, addr and data stable until it sees ready; transfer happens when valid&&ready at posedge.
- Pointer update:
  - On an accepted transfer, rr_ptr <= (grant+1) mod NREQ.
  - With no transfer, rr_ptr holds.
  - Every continuously-valid requester is granted within NREQ cycles.
- Output stage (1-cycle latency):
  - At the edge where a transfer is accepted, the stage loads the transfer's addr and data.
  - In the following cycle: write_en=1, reg_write_en=onehot(addr), write_data=data.
  - With no transfer, the stage clears: write_en=0, reg_write_en=0, and write_data holds its last value.
  - The register file always accepts, so there is no backpressure and one write completes per cycle.
- Register x0:
  - A transfer with addr=0 is accepted (ready=1, pointer advances).
  - The output stage then keeps write_en=0 and reg_write_en=0, so nothing is written.
- Scoreboard, next-state per edge (priority order):
  - rst: all bits 0.
  - flush: all bits 0. Any alloc in the same cycle is ignored. An output stage already loaded still performs its register write.
  - Otherwise busy[out_addr] is cleared at the edge where the output stage presents write_en=1. This is the same edge at which the register file captures the data, so busy never drops before the data is readable.
  - Then busy[alloc_addr] is set if alloc_valid and alloc_addr!=0.
  - If alloc and clear hit the same register in the same cycle, the set wins: a new writer is in flight.
  - busy[0] is constant 0.
- Hazard query:
  - rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr], read combinationally from the registered busy bits.
  - There is no same-cycle bypass of a clear.
  - busy_vec = busy.
- Reset mid-operation: a pending output-stage write is dropped (write_en goes to 0 immediately) and all state returns to reset values.

Decomposition:
- Shared package holds:
  - the constants WIDTH, LENGTH and ADDR_W;
  - a function onehot_decode(addr) returning [0:LENGTH-1];
  - the requester index constants REQ_ALU=0, REQ_LSU=1, REQ_CSR=2.
- One natural sub-module, rr_arbiter: holds the NREQ-way round-robin grant logic and the rr_ptr register. Its inputs are valid and accept; its outputs are a one-hot grant and the grant index.
- The scoreboard and output stage stay in the top level.

Test Plan:
- Single write: after reset, req 0 presents addr=5, data=0xDEADBEEF for 1 cycle.
  - Expect ready[0]=1 that cycle.
  - Next cycle: write_en=1, reg_write_en has only bit 5 set, write_data=0xDEADBEEF.
- Round-robin: all 3 requesters valid for 6 cycles with distinct addrs.
  - Grant order 0,1,2,0,1,2; each addr appears on reg_write_en exactly once per 3 cycles.
- x0 suppression: req 1 writes addr=0, data=0x1234.
  - Expect ready[1]=1 and rr_ptr advances to 2.
  - Next cycle write_en=0 and reg_write_en=0.
- Scoreboard: alloc addr=7, then query rs1_addr=7 for 3 cycles while req 2 writes addr=7.
  - rs1_busy=1 until the edge where write_en=1 for addr 7, then rs1_busy=0.
  - Same-cycle alloc of addr 7 during that write keeps rs1_busy=1.
- Flush: set busy on regs 3, 9 and 12, then pulse flush together with alloc addr=4.
  - Next cycle busy_vec is all zeros.
- Async reset mid-write: assert rst while write_en=1.
  - write_en, reg_write_en and busy_vec go to 0 without waiting for a clock edge.
  - rr_ptr=0 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int WIDTH  = 32;
   localparam int LENGTH = 32;
   localparam int ADDR_W = $clog2(LENGTH);

   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_CSR = 2;

   function automatic logic [0:LENGTH-1] onehot_decode(input logic [ADDR_W-1:0] addr);
      logic [0:LENGTH-1] sel;
      sel       = '0;
      sel[addr] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// NREQ-way round-robin arbiter; the search starts at rr_ptr and the pointer
// moves past the winner whenever the grant is accepted.
module rr_arbiter #(
   parameter int NREQ  = 3,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [0:NREQ-1]  valid_i,
   input  logic             accept_i,
   output logic [0:NREQ-1]  grant_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             found;
   int               cand;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr_q) + k) % NREQ;
         if (!found && valid_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            grant_idx_o   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept_i && found) begin
         ptr_d = (grant_idx_o == IDX_W'(NREQ - 1)) ? '0 : grant_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin over writeback units, one
// registered write stage, and a busy scoreboard for RAW hazard detection.
module regfile_wb_arbiter #(
   parameter int  WIDTH  = regfile_wb_arbiter_pkg::WIDTH,
   parameter int  LENGTH = regfile_wb_arbiter_pkg::LENGTH,
   parameter int  NREQ   = 3,
   localparam int ADDR_W = $clog2(LENGTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [0:NREQ-1]          req_valid,
   output logic [0:NREQ-1]          req_ready,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   input  logic                     alloc_valid,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        rs1_addr,
   input  logic [ADDR_W-1:0]        rs2_addr,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   output logic [0:LENGTH-1]        reg_write_en,
   output logic [0:WIDTH-1]         write_data,
   output logic                     write_en,
   output logic [0:LENGTH-1]        busy_vec
);
   import regfile_wb_arbiter_pkg::*;

   localparam int IDX_W = $clog2(NREQ);

   logic [0:NREQ-1]   grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              transfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [WIDTH-1:0]  sel_data;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [0:LENGTH-1] onehot_q;
   logic [WIDTH-1:0]  data_q;
   logic [0:LENGTH-1] busy_q, busy_d;

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (req_valid),
      .accept_i   (transfer),
      .grant_o    (grant),
      .grant_idx_o(grant_idx)
   );

   assign req_ready = rst ? '0 : grant;
   assign transfer  = |req_ready;
   assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign sel_data  = req_data[int'(grant_idx)*WIDTH +: WIDTH];

   // x0 writes are accepted but never reach the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         onehot_q <= '0;
         data_q   <= '0;
      end else if (transfer) begin
         we_q     <= (sel_addr != '0);
         addr_q   <= sel_addr;
         onehot_q <= (sel_addr != '0) ? onehot_decode(sel_addr) : '0;
         data_q   <= sel_data;
      end else begin
         we_q     <= 1'b0;
         onehot_q <= '0;
      end
   end

   // Clear on the edge the write lands, then a fresh allocation overrides it.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (we_q) begin
            busy_d[addr_q] = 1'b0;
         end
         if (alloc_valid && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign write_en     = we_q;
   assign reg_write_en = onehot_q;
   assign write_data   = data_q;
   assign busy_vec     = busy_q;
   assign rs1_busy     = busy_q[rs1_addr];
   assign rs2_busy     = busy_q[rs2_addr];

endmodule
